// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder and other immgen consumers:
// format select codes, fixed opcodes used by the LI expansion, FSM states
// and a small range-check helper.
package imm_encoder_pkg;

  // Format select codes; all eight values are meaningful.
  typedef enum logic [2:0] {
    SEL_I      = 3'b000,
    SEL_S      = 3'b001,
    SEL_B      = 3'b010,
    SEL_U      = 3'b011,
    SEL_J      = 3'b100,
    SEL_LUI    = 3'b101,
    SEL_LI     = 3'b110,
    SEL_ISHIFT = 3'b111
  } imm_sel_e;

  // Opcodes and funct3 used when LI expands into LUI/ADDI.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI    = 3'b000;

  // Encoder sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EMIT_HI = 2'd1,
    ST_EMIT_LO = 2'd2
  } enc_state_e;

  // True when v[31:msb] are all equal, i.e. v fits a signed (msb+1)-bit field.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] t;
    t = $unsigned($signed(v) >>> msb);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational instruction packing: places the immediate and register
// fields for the selected format and flags immediates that do not fit.
// For LI it produces both candidate words and whether two are needed.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  imm_sel,
  input  logic [31:0] imm_value,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [6:0]  opcode,
  output logic [31:0] first_word,
  output logic [31:0] second_word,
  output logic        two_words,
  output logic        range_err
);

  // Upper 20 bits for LI: adding 0x800 carries into bit 12 exactly when
  // bit 11 is set, which compensates for ADDI sign-extending its 12 bits.
  logic [19:0] li_hi;
  assign li_hi = imm_value[31:12] + {19'd0, imm_value[11]};

  // Format mux and per-format representability check.
  always_comb begin
    first_word  = '0;
    second_word = '0;
    two_words   = 1'b0;
    range_err   = 1'b0;
    case (imm_sel_e'(imm_sel))
      SEL_I: begin
        first_word = {imm_value[11:0], rs1, funct3, rd, opcode};
        range_err  = !fits_signed(imm_value, 11);
      end
      SEL_ISHIFT: begin
        first_word = {funct7, imm_value[4:0], rs1, funct3, rd, opcode};
        range_err  = |imm_value[31:5];
      end
      SEL_S: begin
        first_word = {imm_value[11:5], rs2, rs1, funct3, imm_value[4:0], opcode};
        range_err  = !fits_signed(imm_value, 11);
      end
      SEL_B: begin
        first_word = {imm_value[12], imm_value[10:5], rs2, rs1, funct3,
                      imm_value[4:1], imm_value[11], opcode};
        range_err  = imm_value[0] || !fits_signed(imm_value, 12);
      end
      SEL_U, SEL_LUI: begin
        first_word = {imm_value[31:12], rd, opcode};
        range_err  = |imm_value[11:0];
      end
      SEL_J: begin
        first_word = {imm_value[20], imm_value[10:1], imm_value[11],
                      imm_value[19:12], rd, opcode};
        range_err  = imm_value[0] || !fits_signed(imm_value, 20);
      end
      SEL_LI: begin
        if (li_hi != 20'd0) begin
          first_word  = {li_hi, rd, OPC_LUI};
          second_word = {imm_value[11:0], rd, F3_ADDI, rd, OPC_OP_IMM};
          two_words   = 1'b1;
        end else begin
          first_word  = {imm_value[11:0], 5'd0, F3_ADDI, rd, OPC_OP_IMM};
        end
      end
      default: begin
        first_word = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: accepts one request per cycle, registers the packed
// instruction word, and sequences the two-word LUI/ADDI expansion of LI.
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_sel,
  input  logic [31:0] imm_value,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [6:0]  opcode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        out_last,
  output logic        range_err
);

  enc_state_e  state_reg;
  logic        out_valid_reg;
  logic [31:0] instr_reg;
  logic        out_last_reg;
  logic        range_err_reg;
  logic [31:0] lo_word_reg;

  logic [31:0] pack_first;
  logic [31:0] pack_second;
  logic        pack_two;
  logic        pack_err;
  logic        accept;
  logic        handshake;

  imm_pack u_pack (
    .imm_sel     (imm_sel),
    .imm_value   (imm_value),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct3      (funct3),
    .funct7      (funct7),
    .opcode      (opcode),
    .first_word  (pack_first),
    .second_word (pack_second),
    .two_words   (pack_two),
    .range_err   (pack_err)
  );

  // New requests only while idle and the output slot is free or draining.
  assign in_ready  = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_reg && out_ready;

  assign out_valid = out_valid_reg;
  assign instr     = instr_reg;
  assign out_last  = out_last_reg;
  assign range_err = range_err_reg;

  // Sequencer and output register; the held ADDI word waits in lo_word_reg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      instr_reg     <= '0;
      out_last_reg  <= 1'b0;
      range_err_reg <= 1'b0;
      lo_word_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            out_valid_reg <= 1'b1;
            instr_reg     <= pack_first;
            out_last_reg  <= !pack_two;
            range_err_reg <= pack_err;
            if (pack_two) begin
              lo_word_reg <= pack_second;
              state_reg   <= ST_EMIT_HI;
            end
          end else if (handshake) begin
            out_valid_reg <= 1'b0;
          end
        end
        ST_EMIT_HI: begin
          if (handshake) begin
            instr_reg     <= lo_word_reg;
            out_last_reg  <= 1'b1;
            range_err_reg <= 1'b0;
            state_reg     <= ST_EMIT_LO;
          end
        end
        ST_EMIT_LO: begin
          if (handshake) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors, a back-to-back stream, reset
// mid-sequence, and randomized requests against a reference model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_sel;
  logic [31:0] imm_value;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7, opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        out_last;
  logic        range_err;

  int checks = 0;
  int errors = 0;

  imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_sel   (imm_sel),
    .imm_value (imm_value),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .out_last  (out_last),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: builds words from field positions with shifts/masks and
  // decides representability with signed integer ranges.
  function automatic void model(input bit [2:0] sel, input bit [31:0] imm,
                                input bit [4:0] rd_i, input bit [4:0] rs1_i,
                                input bit [4:0] rs2_i, input bit [2:0] f3_i,
                                input bit [6:0] f7_i, input bit [6:0] opc_i,
                                output int n, output bit [31:0] w0,
                                output bit [31:0] w1, output bit e);
    bit [31:0] r_d, r_1, r_2, f3, f7, op, hi, lo;
    longint s;
    r_d = 32'(rd_i); r_1 = 32'(rs1_i); r_2 = 32'(rs2_i);
    f3 = 32'(f3_i); f7 = 32'(f7_i); op = 32'(opc_i);
    s = longint'($signed(imm));
    n = 1; w0 = 0; w1 = 0; e = 0;
    case (sel)
      3'd0: begin
        w0 = ((imm & 32'hFFF) << 20) | (r_1 << 15) | (f3 << 12) | (r_d << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        w0 = (((imm >> 5) & 32'h7F) << 25) | (r_2 << 20) | (r_1 << 15) | (f3 << 12)
           | ((imm & 32'h1F) << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (r_2 << 20)
           | (r_1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
           | (((imm >> 11) & 1) << 7) | op;
        e = (imm % 2 != 0) || (s < -4096) || (s > 4094);
      end
      3'd3, 3'd5: begin
        w0 = (imm & 32'hFFFFF000) | (r_d << 7) | op;
        e = (imm % 4096) != 0;
      end
      3'd4: begin
        w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
           | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (r_d << 7) | op;
        e = (imm % 2 != 0) || (s < -1048576) || (s > 1048575);
      end
      3'd7: begin
        w0 = (f7 << 25) | ((imm & 32'h1F) << 20) | (r_1 << 15) | (f3 << 12) | (r_d << 7) | op;
        e = imm >= 32;
      end
      default: begin
        hi = (imm + 32'd2048) >> 12;
        lo = imm & 32'hFFF;
        if (hi != 0) begin
          n = 2;
          w0 = (hi << 12) | (r_d << 7) | 32'h37;
          w1 = (lo << 20) | (r_d << 15) | (r_d << 7) | 32'h13;
        end else begin
          w0 = (lo << 20) | (r_d << 7) | 32'h13;
        end
      end
    endcase
  endfunction

  // One request start to finish; called at a negedge with the output idle.
  task automatic run_req(input bit [2:0] sel, input bit [31:0] imm,
                         input bit [4:0] rd_i, input bit [4:0] rs1_i, input bit [4:0] rs2_i,
                         input bit [2:0] f3_i, input bit [6:0] f7_i, input bit [6:0] opc_i,
                         input int bp, input int n, input bit [31:0] w0,
                         input bit [31:0] w1, input bit e, input string tag);
    int waited;
    bit [31:0] exp_w;
    imm_sel = sel; imm_value = imm; rd = rd_i; rs1 = rs1_i; rs2 = rs2_i;
    funct3 = f3_i; funct7 = f7_i; opcode = opc_i;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check1({tag, "_in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check1({tag, "_latency"}, out_valid, 1'b1);
    for (int k = 0; k < n; k++) begin
      exp_w = (k == 0) ? w0 : w1;
      if (k == 0 && bp > 0) begin
        out_ready = 1'b0;
        for (int c = 0; c < bp; c++) begin
          #1;
          check32({tag, "_hold_instr"}, instr, exp_w);
          check1({tag, "_hold_last"}, out_last, (k == n - 1));
          check1({tag, "_hold_ready"}, in_ready, 1'b0);
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      #1;
      check1({tag, "_valid"}, out_valid, 1'b1);
      check32({tag, "_instr"}, instr, exp_w);
      check1({tag, "_last"}, out_last, (k == n - 1));
      check1({tag, "_err"}, range_err, e);
      check1({tag, "_in_ready_busy"}, in_ready, (n == 1));
      @(negedge clk);
    end
    check1({tag, "_drained"}, out_valid, 1'b0);
    check1({tag, "_ready_after"}, in_ready, 1'b1);
    $display("req %s sel=%0d imm=%h words=%0d w0=%h w1=%h err=%0d bp=%0d",
             tag, sel, imm, n, w0, w1, e, bp);
  endtask

  task automatic run_model_req(input bit [2:0] sel, input bit [31:0] imm, input int bp,
                               input string tag);
    bit [4:0] r_d, r_1, r_2;
    bit [2:0] f3;
    bit [6:0] f7, op;
    int n;
    bit [31:0] w0, w1;
    bit e;
    r_d = 5'($urandom_range(0, 31)); r_1 = 5'($urandom_range(0, 31));
    r_2 = 5'($urandom_range(0, 31)); f3 = 3'($urandom_range(0, 7));
    f7 = 7'($urandom_range(0, 127)); op = 7'($urandom_range(0, 127));
    model(sel, imm, r_d, r_1, r_2, f3, f7, op, n, w0, w1, e);
    run_req(sel, imm, r_d, r_1, r_2, f3, f7, op, bp, n, w0, w1, e, tag);
  endtask

  bit [31:0] edges [14] = '{32'd0, 32'd1, 32'd31, 32'd32, 32'd2047, 32'd2048,
                            32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4096,
                            32'hFFFFF000, 32'h000FFFFE, 32'h00100000, 32'hFFF00000};

  initial begin
    int n_s [8];
    bit [31:0] w0_s [8];
    bit [31:0] w1_s [8];
    bit e_s [8];
    bit [2:0] sel;
    bit [31:0] imm;
    bit [4:0] r_d, r_1, r_2;
    bit [2:0] f3;
    bit [6:0] f7, op;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    imm_sel = '0; imm_value = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; opcode = '0;
    #1;
    check1("reset_valid", out_valid, 1'b0);
    check32("reset_instr", instr, 32'h0);
    check1("reset_last", out_last, 1'b0);
    check1("reset_err", range_err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check1("reset_in_ready", in_ready, 1'b1);

    // Directed vectors
    run_req(3'd0, 32'hFFFFFFFF, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 7'h13, 0,
            1, 32'hFFF10093, 32'h0, 1'b0, "i_neg1");
    run_req(3'd6, 32'h12345FFF, 5'd5, 5'd31, 5'd31, 3'd7, 7'h7F, 7'h7F, 0,
            2, 32'h123462B7, 32'hFFF28293, 1'b0, "li_two");
    run_req(3'd6, 32'h000007FF, 5'd5, 5'd9, 5'd9, 3'd3, 7'd0, 7'h33, 0,
            1, 32'h7FF00293, 32'h0, 1'b0, "li_one");
    run_req(3'd2, 32'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h63, 0,
            1, 32'h00000163, 32'h0, 1'b1, "b_odd");
    run_req(3'd7, 32'd32, 5'd0, 5'd0, 5'd0, 3'd1, 7'd0, 7'h13, 0,
            1, 32'h00001013, 32'h0, 1'b1, "shift_32");
    run_req(3'd0, 32'd5, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 7'h13, 3,
            1, 32'h00520193, 32'h0, 1'b0, "backpressure");
    run_req(3'd0, 32'hFFFFF800, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13, 0,
            1, 32'h80000013, 32'h0, 1'b0, "i_min");
    run_req(3'd0, 32'h00000800, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h13, 0,
            1, 32'h80000013, 32'h0, 1'b1, "i_over");
    run_req(3'd3, 32'h12345001, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h37, 0,
            1, 32'h12345037, 32'h0, 1'b1, "u_low_bits");
    run_req(3'd6, 32'h12345FFF, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 7'h0, 2,
            2, 32'h123462B7, 32'hFFF28293, 1'b0, "li_bp");

    // Back-to-back stream of non-LI requests with out_ready held high
    out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        sel = 3'($urandom_range(0, 6));
        if (sel == 3'd6) sel = 3'd7;
        imm = $urandom();
        r_d = 5'($urandom_range(0, 31)); r_1 = 5'($urandom_range(0, 31));
        r_2 = 5'($urandom_range(0, 31)); f3 = 3'($urandom_range(0, 7));
        f7 = 7'($urandom_range(0, 127)); op = 7'($urandom_range(0, 127));
        model(sel, imm, r_d, r_1, r_2, f3, f7, op, n_s[k], w0_s[k], w1_s[k], e_s[k]);
        imm_sel = sel; imm_value = imm; rd = r_d; rs1 = r_1; rs2 = r_2;
        funct3 = f3; funct7 = f7; opcode = op;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k > 0) begin
        check1("stream_valid", out_valid, 1'b1);
        check32("stream_instr", instr, w0_s[k-1]);
        check1("stream_err", range_err, e_s[k-1]);
        $display("stream word %0d instr=%h expected=%h", k - 1, instr, w0_s[k-1]);
      end
      if (k < 8) check1("stream_in_ready", in_ready, 1'b1);
      @(negedge clk);
    end
    check1("stream_drained", out_valid, 1'b0);

    // Reset after the LUI handshake, before the ADDI handshake
    imm_sel = 3'd6; imm_value = 32'h12345FFF; rd = 5'd5; in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check32("rst_seq_lui", instr, 32'h123462B7);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check32("rst_seq_addi_pending", instr, 32'hFFF28293);
    rst = 1'b1;
    #1;
    check1("rst_seq_valid", out_valid, 1'b0);
    check32("rst_seq_instr", instr, 32'h0);
    check1("rst_seq_last", out_last, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check1("rst_seq_in_ready", in_ready, 1'b1);
    check1("rst_seq_no_addi", out_valid, 1'b0);
    @(negedge clk);
    check1("rst_seq_still_idle", out_valid, 1'b0);
    $display("req reset_mid_li discarded pending ADDI");

    // Randomized requests against the model
    for (int t = 0; t < 60; t++) begin
      sel = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: imm = $urandom();
        1: imm = edges[$urandom_range(0, 13)];
        2: imm = $urandom_range(0, 8191) - 32'd4096;
        default: imm = $urandom_range(0, 4194304) - 32'd2097152;
      endcase
      run_model_req(sel, imm, $urandom_range(0, 2), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have in_valid  input  1  request present; in_ready  output  1  request accepted on the clk edge where in_valid && in_ready.
REQ-004 SHALL have imm_sel  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 LUI, 110 LI pseudo, 111 I-shift.
REQ-005 SHALL have imm_value  input  32  immediate as a signed/byte-offset value (not pre-shifted).
REQ-006 SHALL have rd  input  5; rs1  input  5; rs2  input  5; funct3  input  3; funct7  input  7; opcode  input  7  register/opcode fields.
REQ-007 SHALL have out_valid  output  1; out_ready  input  1  output handshake, word transferred when both are high.
REQ-008 SHALL have instr  output  32  encoded instruction word; out_last  output  1  final word of the request; range_err  output  1  immediate not representable.

Function
REQ-009 SHALL assert in_ready only when the FSM is in IDLE and (!out_valid || out_ready).
REQ-010 SHALL register the output on accept: out_valid rises exactly 1 cycle after the accepting edge.
REQ-011 SHALL hold instr, out_last and range_err stable while out_valid && !out_ready.
REQ-012 SHALL encode I: {imm[11:0], rs1, funct3, rd, opcode}; range_err if imm is outside -2048..2047.
REQ-013 SHALL encode I-shift: {funct7, imm[4:0], rs1, funct3, rd, opcode}; range_err if imm[31:5] != 0.
REQ-014 SHALL encode S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; range_err as for I.
REQ-015 SHALL encode B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; range_err if imm[0] is set or imm is outside -4096..4094.
REQ-016 SHALL encode U and LUI: {imm[31:12], rd, opcode}; range_err if imm[11:0] != 0.
REQ-017 SHALL encode J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; range_err if imm[0] is set or imm is outside signed 21-bit range.
REQ-018 SHALL, on range_err, still emit the word with truncated fields, single word, out_last=1.
REQ-019 SHALL implement LI (110) as: lo = imm[11:0] sign-extended; hi = (imm + 0x800) >> 12 modulo 2^32, 20 bits; ignores the opcode/funct3/rs1/rs2 inputs; range_err=0.
REQ-020 SHALL, for LI with hi != 0, emit LUI rd,hi (opcode 0110111, out_last=0) and then ADDI rd,rd,lo (opcode 0010011, funct3 000, out_last=1).
REQ-021 SHALL, for LI with hi == 0, emit only ADDI rd,x0,lo with out_last=1.
REQ-022 SHALL present the second LI word 1 cycle after the first word's handshake; in_ready SHALL stay low until the last word's handshake.
REQ-023 SHALL use FSM states IDLE, EMIT_HI, EMIT_LO: IDLE->EMIT_HI on accepted LI with hi!=0; EMIT_HI->EMIT_LO on handshake; EMIT_LO->IDLE on handshake. All other requests remain in IDLE.
REQ-024 SHALL sustain one accepted non-LI request per cycle when out_ready is held high.
REQ-025 SHALL treat imm_sel values with undefined behaviour as none: all eight codes are defined.

Reset
REQ-026 SHALL, while rst is high, force state=IDLE, out_valid=0, instr=0, out_last=0, range_err=0, independent of clk.
REQ-027 SHALL discard any pending LI second word on reset; in_ready SHALL go high on the first clk edge after rst falls.

Structure
REQ-028 SHALL take imm_sel codes, LUI/OP-IMM opcode constants and FSM state encodings from the shared core package; these are shared with immgen consumers.
REQ-029 SHALL place the combinational format packing and range check in one sub-module, imm_pack; imm_encoder holds the FSM and the output register.

Verification
REQ-030 I: imm=0xFFFFFFFF, rd=1, rs1=2, funct3=0, opcode=0010011 -> instr=0xFFF10093, range_err=0, out_last=1, 1 cycle after accept.
REQ-031 LI: rd=5, imm=0x12345FFF -> 0x123462B7 (out_last=0), then 0xFFF28293 (out_last=1); in_ready low throughout.
REQ-032 LI: rd=5, imm=0x000007FF -> single word 0x7FF00293, out_last=1.
REQ-033 B: imm=3 -> range_err=1; I-shift: imm=32 -> range_err=1; word still emitted, out_last=1.
REQ-034 Backpressure: out_ready low for 3 cycles with out_valid high -> instr/out_last stable and in_ready=0; the word transfers on the cycle out_ready rises.
REQ-035 Reset after the LUI handshake, before the ADDI handshake -> out_valid=0 immediately, no ADDI word emitted, in_ready=1 on the first edge after rst falls.
